// File: rtl/uart_alu_sequencer.sv
// Sequences three serial bytes (A, B, opcode) into registered ALU operands, then sends
// the captured ALU result back through the transmitter using a start/busy handshake.
module uart_alu_sequencer #(
    parameter int NB_DATA        = 8,
    parameter int NB_OP          = 6,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic [NB_DATA-1:0] i_rx_data,
    input  logic               i_rx_done,
    input  logic [NB_DATA-1:0] i_alu_result,
    input  logic               i_tx_busy,
    output logic [NB_DATA-1:0] o_data_a,
    output logic [NB_DATA-1:0] o_data_b,
    output logic [NB_OP-1:0]   o_operation,
    output logic [NB_DATA-1:0] o_tx_data,
    output logic               o_tx_start,
    output logic               o_frame_err,
    output logic [2:0]         o_state
);

    // Handshakes: i_rx_done is a one-cycle strobe qualifying i_rx_data, with no back-pressure;
    // bytes arriving while a result is in flight are dropped. o_tx_start is a one-cycle
    // request issued only while i_tx_busy is low; the transmitter then raises i_tx_busy for
    // the length of the transfer, and its fall releases the sequencer for the next frame.

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_A       = 3'd0,
        ST_B       = 3'd1,
        ST_OP      = 3'd2,
        ST_EXEC    = 3'd3,
        ST_SEND    = 3'd4,
        ST_TX_BUSY = 3'd5,
        ST_TX_DONE = 3'd6
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] idle_cnt_q;
    logic             wait_byte;
    logic             timeout_hit;

    assign o_state = state_q;

    // Only the middle of a frame is timed; a byte in the limit cycle still counts.
    assign wait_byte   = (state_q == ST_B) || (state_q == ST_OP);
    assign timeout_hit = wait_byte && !i_rx_done && (idle_cnt_q == CNT_LIMIT);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_A: begin
                if (i_rx_done) state_d = ST_B;
            end
            ST_B: begin
                if (i_rx_done)        state_d = ST_OP;
                else if (timeout_hit) state_d = ST_A;
            end
            ST_OP: begin
                if (i_rx_done)        state_d = ST_EXEC;
                else if (timeout_hit) state_d = ST_A;
            end
            ST_EXEC: begin
                if (!i_tx_busy) state_d = ST_SEND;
            end
            ST_SEND: begin
                state_d = ST_TX_BUSY;
            end
            ST_TX_BUSY: begin
                if (i_tx_busy) state_d = ST_TX_DONE;
            end
            ST_TX_DONE: begin
                if (!i_tx_busy) state_d = ST_A;
            end
            default: begin
                state_d = ST_A;
            end
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= ST_A;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            idle_cnt_q <= '0;
        end else if (wait_byte && !i_rx_done && !timeout_hit) begin
            idle_cnt_q <= idle_cnt_q + 1'b1;
        end else begin
            idle_cnt_q <= '0;
        end
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            o_data_a    <= '0;
            o_data_b    <= '0;
            o_operation <= '0;
            o_tx_data   <= '0;
            o_tx_start  <= 1'b0;
            o_frame_err <= 1'b0;
        end else begin
            // Registered Moore-style pulses, aligned with residency in ST_SEND / the abort.
            o_tx_start  <= (state_d == ST_SEND);
            o_frame_err <= timeout_hit;
            if (i_rx_done) begin
                case (state_q)
                    ST_A:    o_data_a    <= i_rx_data;
                    ST_B:    o_data_b    <= i_rx_data;
                    ST_OP:   o_operation <= i_rx_data[NB_OP-1:0];
                    default: ;
                endcase
            end
            // The ALU sees the new opcode one cycle after capture, so sample while waiting here.
            if (state_q == ST_EXEC) begin
                o_tx_data <= i_alu_result;
            end
        end
    end

endmodule
